// File: rtl/alu_dispatch_if.sv
// Command, ALU-side and response signal bundle for alu_dispatch.
// slave = dispatcher view, master = environment (command source / ALU / response sink).
interface alu_dispatch_if #(
  parameter int unsigned TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic [TAG_W-1:0] cmd_tag;

  logic             alu_start;
  logic [2:0]       alu_op;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic             alu_done;
  logic [15:0]      alu_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [15:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic [2:0]       rsp_op;
  logic             rsp_err;

  logic             busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, alu_done, alu_result, rsp_ready,
    output cmd_ready, alu_start, alu_op, alu_a, alu_b,
           rsp_valid, rsp_result, rsp_tag, rsp_op, rsp_err, busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, alu_done, alu_result, rsp_ready,
    input  cmd_ready, alu_start, alu_op, alu_a, alu_b,
           rsp_valid, rsp_result, rsp_tag, rsp_op, rsp_err, busy
  );
endinterface

// File: rtl/alu_dispatch.sv
// Buffers ALU commands in a FIFO and issues them one at a time to alu_top,
// with a completion watchdog, illegal-opcode rejection and a held response.
module alu_dispatch #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  alu_dispatch_if.slave bus
);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);
  localparam int unsigned EW  = 3 + 8 + 8 + TAG_W;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_t;
  state_t r_state, w_next;

  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic [EW-1:0]    w_head;
  logic             w_empty, w_full, w_push, w_pop, w_bad_op, w_timeout;
  logic [WDW-1:0]   r_wd;
  logic [TAG_W-1:0] r_hold_tag;
  logic [2:0]       r_hold_op;
  logic [2:0]       r_alu_op;
  logic [7:0]       r_alu_a, r_alu_b;
  logic [15:0]      r_rsp_result;
  logic [TAG_W-1:0] r_rsp_tag;
  logic [2:0]       r_rsp_op;
  logic             r_rsp_err;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_push    = bus.cmd_valid && !w_full;
  assign w_pop     = (r_state == S_IDLE) && !w_empty && !bus.alu_done;
  assign w_bad_op  = (w_head[EW-1 -: 3] == 3'b111);
  assign w_timeout = (r_wd == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b, bus.cmd_tag};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_pop) w_next = w_bad_op ? S_RESP : S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (bus.alu_done || w_timeout) w_next = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_next = S_DRAIN;
      S_DRAIN: if (!bus.alu_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = !w_full;
    bus.alu_start = (r_state == S_ISSUE);
    bus.rsp_valid = (r_state == S_RESP);
    bus.busy      = (r_state != S_IDLE) || !w_empty;
  end

  // Response fields change only on entry to RESP, so they are stable while rsp_valid is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alu_op     <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_hold_tag   <= '0;
      r_hold_op    <= '0;
      r_wd         <= '0;
      r_rsp_result <= '0;
      r_rsp_tag    <= '0;
      r_rsp_op     <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop && w_bad_op) begin
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b1;
            r_rsp_tag    <= w_head[TAG_W-1:0];
            r_rsp_op     <= 3'b111;
          end else if (w_pop) begin
            r_alu_op   <= w_head[EW-1 -: 3];
            r_alu_a    <= w_head[TAG_W+15 -: 8];
            r_alu_b    <= w_head[TAG_W+7 -: 8];
            r_hold_tag <= w_head[TAG_W-1:0];
            r_hold_op  <= w_head[EW-1 -: 3];
          end
        end
        S_ISSUE: r_wd <= '0;
        S_WAIT: begin
          if (bus.alu_done) begin
            r_rsp_result <= bus.alu_result;
            r_rsp_err    <= 1'b0;
            r_rsp_tag    <= r_hold_tag;
            r_rsp_op     <= r_hold_op;
          end else if (w_timeout) begin
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b1;
            r_rsp_tag    <= r_hold_tag;
            r_rsp_op     <= r_hold_op;
          end else begin
            r_wd <= r_wd + WDW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.alu_op     = r_alu_op;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_tag    = r_rsp_tag;
  assign bus.rsp_op     = r_rsp_op;
  assign bus.rsp_err    = r_rsp_err;
endmodule
